// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the operand-fetch state encoding.
// The multiplexer and ALU stages size their ports from the same constants.
package cpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int SEL_WIDTH  = 2;
  localparam int OPC_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    VALID
  } fetch_state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of the decode, multiplexer and ALU-side signals of the operand fetch stage.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; the
// sender holds valid and payload stable until that edge, and ready may depend on state only.
interface operand_fetch_if;
  import cpu_pkg::*;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [OPC_WIDTH-1:0]  instr_opc;
  logic [SEL_WIDTH-1:0]  instr_src_a;
  logic [SEL_WIDTH-1:0]  instr_src_b;

  logic [SEL_WIDTH-1:0]  mux_select;
  logic [DATA_WIDTH-1:0] mux_out;

  logic                  op_valid;
  logic                  op_ready;
  logic [OPC_WIDTH-1:0]  op_opc;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  modport master (
    input  instr_valid, instr_opc, instr_src_a, instr_src_b, mux_out, op_ready,
    output instr_ready, mux_select, op_valid, op_opc, op_a, op_b
  );

  modport slave (
    output instr_valid, instr_opc, instr_src_a, instr_src_b, mux_out, op_ready,
    input  instr_ready, mux_select, op_valid, op_opc, op_a, op_b
  );

endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: steers the external 4:1 mux with src_a then src_b, captures each
// operand on its own edge, and offers {opcode, A, B} to the ALU over valid/ready.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  operand_fetch_if.master bus,
  output fetch_state_t    state
);

  logic [OPC_WIDTH-1:0]  opc_q;
  logic [SEL_WIDTH-1:0]  src_b_q;
  logic [SEL_WIDTH-1:0]  mux_select_q;
  logic                  op_valid_q;
  logic [OPC_WIDTH-1:0]  op_opc_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;

  // The bank is not locked: each operand is whatever the mux shows at its own capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      opc_q        <= '0;
      src_b_q      <= '0;
      mux_select_q <= '0;
      op_valid_q   <= 1'b0;
      op_opc_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            opc_q        <= bus.instr_opc;
            src_b_q      <= bus.instr_src_b;
            mux_select_q <= bus.instr_src_a;
            state        <= FETCH_A;
          end
        end
        FETCH_A: begin
          op_a_q       <= bus.mux_out;
          mux_select_q <= src_b_q;
          state        <= FETCH_B;
        end
        FETCH_B: begin
          op_b_q     <= bus.mux_out;
          op_opc_q   <= opc_q;
          op_valid_q <= 1'b1;
          state      <= VALID;
        end
        VALID: begin
          if (bus.op_ready) begin
            op_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.mux_select  = mux_select_q;
  assign bus.op_valid    = op_valid_q;
  assign bus.op_opc      = op_opc_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch driving a behavioural 4:1 register-bank mux.
// Directed table vectors and corner sequences, then random traffic against a queue model.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  fetch_state_t state;
  logic [7:0]   bank [4];

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  assign bus.mux_out = bank[bus.mux_select];

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] opc;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t tbl [6];
  logic [19:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction and returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] opc, input logic [1:0] a, input logic [1:0] b);
    int guard = 0;
    bus.instr_valid = 1'b1;
    bus.instr_opc   = opc;
    bus.instr_src_a = a;
    bus.instr_src_b = b;
    while (bus.instr_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: instr_ready never rose, got 0 expected 1");
    end
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [3:0] opc,
                           input logic [7:0] a, input logic [7:0] b);
    check({name, "_valid"}, 32'(bus.op_valid), 32'(1'b1));
    check({name, "_opc"},   32'(bus.op_opc),   32'(opc));
    check({name, "_a"},     32'(bus.op_a),     32'(a));
    check({name, "_b"},     32'(bus.op_b),     32'(b));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bank = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.instr_valid = 1'b0;
    bus.instr_opc   = '0;
    bus.instr_src_a = '0;
    bus.instr_src_b = '0;
    bus.op_ready    = 1'b0;

    tbl[0] = '{4'h0, 2'd0, 2'd0, 8'h11, 8'h11};
    tbl[1] = '{4'hF, 2'd3, 2'd3, 8'h44, 8'h44};
    tbl[2] = '{4'h7, 2'd0, 2'd3, 8'h11, 8'h44};
    tbl[3] = '{4'hA, 2'd3, 2'd0, 8'h44, 8'h11};
    tbl[4] = '{4'h5, 2'd1, 2'd2, 8'h22, 8'h33};
    tbl[5] = '{4'hC, 2'd2, 2'd3, 8'h33, 8'h44};

    // 1. Reset
    repeat (2) tick();
    check("rst_hold_valid", 32'(bus.op_valid), 32'(1'b0));
    rst_n = 1'b1;
    tick();
    check("rst_mux_select", 32'(bus.mux_select), 32'(2'd0));
    check("rst_op_valid",   32'(bus.op_valid),   32'(1'b0));
    check("rst_op_a",       32'(bus.op_a),       32'(8'h00));
    check("rst_op_b",       32'(bus.op_b),       32'(8'h00));
    check("rst_op_opc",     32'(bus.op_opc),     32'(4'h0));
    check("rst_instr_ready",32'(bus.instr_ready),32'(1'b1));

    // 2. Basic latency and handshake
    bus.op_ready = 1'b1;
    send(4'h3, 2'd2, 2'd1);
    check("basic_e0_valid", 32'(bus.op_valid),   32'(1'b0));
    check("basic_e0_sel",   32'(bus.mux_select), 32'(2'd2));
    check("basic_e0_ready", 32'(bus.instr_ready),32'(1'b0));
    tick();
    check("basic_e1_valid", 32'(bus.op_valid),   32'(1'b0));
    check("basic_e1_sel",   32'(bus.mux_select), 32'(2'd1));
    check("basic_e1_a",     32'(bus.op_a),       32'(8'h33));
    tick();
    check_out("basic_e2", 4'h3, 8'h33, 8'h22);
    tick();
    check("basic_done_valid", 32'(bus.op_valid),   32'(1'b0));
    check("basic_done_ready", 32'(bus.instr_ready),32'(1'b1));

    // Table vectors with the ALU always ready
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].opc, tbl[i].src_a, tbl[i].src_b);
      repeat (2) tick();
      check_out($sformatf("tbl%0d", i), tbl[i].opc, tbl[i].exp_a, tbl[i].exp_b);
      tick();
      check($sformatf("tbl%0d_drop", i), 32'(bus.op_valid), 32'(1'b0));
    end

    // 3. Backpressure, with decode offering a new instruction that must be ignored
    bus.op_ready = 1'b0;
    send(4'h9, 2'd3, 2'd0);
    repeat (2) tick();
    bus.instr_valid = 1'b1;
    bus.instr_opc   = 4'h1;
    bus.instr_src_a = 2'd1;
    bus.instr_src_b = 2'd1;
    for (int i = 0; i < 5; i++) begin
      check_out($sformatf("bp%0d", i), 4'h9, 8'h44, 8'h11);
      check($sformatf("bp%0d_ready", i), 32'(bus.instr_ready), 32'(1'b0));
      tick();
    end
    bus.instr_valid = 1'b0;
    bus.op_ready = 1'b1;
    tick();
    check("bp_xfer_valid", 32'(bus.op_valid), 32'(1'b0));
    bus.op_ready = 1'b0;
    tick();
    check("bp_single_xfer", 32'(bus.op_valid), 32'(1'b0));
    check("bp_idle_ready",  32'(bus.instr_ready), 32'(1'b1));

    // 4. Same source, then the bank changes between the two capture edges
    bus.op_ready = 1'b1;
    send(4'h2, 2'd1, 2'd1);
    repeat (2) tick();
    check_out("same", 4'h2, 8'h22, 8'h22);
    tick();
    send(4'h4, 2'd1, 2'd1);
    tick();
    bank[1] = 8'h99;
    tick();
    check_out("same_chg", 4'h4, 8'h22, 8'h99);
    tick();
    bank[1] = 8'h22;

    // 5. Abort in FETCH_B
    send(4'h6, 2'd2, 2'd3);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus.op_valid),   32'(1'b0));
    check("abort_a",     32'(bus.op_a),       32'(8'h00));
    check("abort_b",     32'(bus.op_b),       32'(8'h00));
    check("abort_opc",   32'(bus.op_opc),     32'(4'h0));
    check("abort_sel",   32'(bus.mux_select), 32'(2'd0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("abort_quiet%0d", i), 32'(bus.op_valid), 32'(1'b0));
    end
    send(4'h1, 2'd0, 2'd3);
    repeat (2) tick();
    check_out("post_abort", 4'h1, 8'h11, 8'h44);
    tick();

    // 6. Random traffic against a queue model
    bus.op_ready = 1'b0;
    for (int i = 0; i < 4; i++) bank[i] = 8'($urandom_range(0, 255));
    fork
      begin : driver
        for (int n = 0; n < 200; n++) begin
          logic [3:0] opc;
          logic [1:0] a, b;
          repeat ($urandom_range(0, 2)) tick();
          opc = 4'($urandom_range(0, 15));
          a   = 2'($urandom_range(0, 3));
          b   = 2'($urandom_range(0, 3));
          send(opc, a, b);
          exp_q.push_back({opc, bank[a], bank[b]});
        end
      end
      begin : monitor
        int got = 0;
        int cyc = 0;
        logic hold = 1'b0;
        logic [19:0] prev = '0;
        logic [19:0] cur;
        logic [19:0] exp;
        while (got < 200 && cyc < 20000) begin
          bus.op_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          cur = {bus.op_opc, bus.op_a, bus.op_b};
          if (hold) begin
            check("rnd_hold_valid", 32'(bus.op_valid), 32'(1'b1));
            check("rnd_hold_data",  32'(cur),          32'(prev));
          end
          if (bus.op_valid)
            check("rnd_ready_in_valid", 32'(bus.instr_ready), 32'(1'b0));
          if (bus.op_valid && bus.op_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL rnd_unexpected: got %0h, expected no output", cur);
            end else begin
              exp = exp_q.pop_front();
              check($sformatf("rnd_xfer%0d", got), 32'(cur), 32'(exp));
            end
            got++;
          end
          hold = bus.op_valid && !bus.op_ready;
          prev = cur;
          tick();
          cyc++;
        end
        if (got < 200) begin
          n_checks++;
          n_errors++;
          $display("FAIL rnd_timeout: got %0d transfers, expected 200", got);
        end
      end
    join
    check("rnd_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
